// File: rtl/demosaic_pkg.sv
// Shared types and default sizes for the Bayer demosaic pixel path.
package demosaic_pkg;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_pat_e;

  localparam int unsigned DATA_W_DEF   = 12;
  localparam int unsigned MAX_LINE_DEF = 1280;
  localparam int unsigned CNT_W_DEF    = 11;

endpackage

// File: rtl/demosaic_line_buf.sv
// One-line sample store: combinational read of the previous row, write on the clock edge.
module demosaic_line_buf
  import demosaic_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LINE = MAX_LINE_DEF,
  localparam int unsigned ADDR_W  = $clog2(MAX_LINE)
) (
  input  logic              iCLK,
  input  logic              iWE,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic [DATA_W-1:0] oRdData_c
);

  logic [DATA_W-1:0] mem [MAX_LINE];

  // Read sees the old contents in the cycle of the write (read-before-write).
  always_ff @(posedge iCLK) begin
    if (iWE) mem[iAddr] <= iWrData;
  end

  assign oRdData_c = mem[iAddr];

endmodule

// File: rtl/bayer_demosaic_px.sv
// 2x2 quad Bayer demosaic, one RGB pixel per quad. Optional grayscale output
// is built only when DEMOSAIC_GRAY_EN is defined.
module bayer_demosaic_px
  import demosaic_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LINE = MAX_LINE_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [CNT_W-1:0]  iLineLen,
  input  logic [1:0]        iPattern,
  input  logic              iGray,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic              oSOF
);

  localparam int unsigned ADDR_W = $clog2(MAX_LINE);

  logic              accept, frameStart, primeEvt, quadEvt;
  logic [DATA_W-1:0] rdData, blDly, tlDly;
  logic [DATA_W-1:0] r, g0, g1, b;
  logic [DATA_W:0]   greenSum;
  logic [DATA_W-1:0] nextRed, nextGreen, nextBlue;
  bayer_pat_e        patLat;
  logic              primed, sofPend;

  assign accept     = iDVAL && (iX_Cont < iLineLen);
  assign frameStart = accept && (iX_Cont == '0) && (iY_Cont == '0);
  assign primeEvt   = accept && (iX_Cont == '0) && !iY_Cont[0];
  assign quadEvt    = accept && iX_Cont[0] && iY_Cont[0] && primed;

  demosaic_line_buf #(
    .DATA_W   (DATA_W),
    .MAX_LINE (MAX_LINE)
  ) u_lineBuf (
    .iCLK      (iCLK),
    .iWE       (accept),
    .iAddr     (ADDR_W'(iX_Cont)),
    .iWrData   (iDATA),
    .oRdData_c (rdData)
  );

  // Map quad corners (TL=tlDly, TR=rdData, BL=blDly, BR=iDATA) to colour planes.
  always_comb begin
    r  = tlDly;
    g0 = rdData;
    g1 = blDly;
    b  = iDATA;
    case (patLat)
      GRBG:    begin r = rdData; g0 = tlDly; g1 = iDATA;  b = blDly;  end
      GBRG:    begin r = blDly;  g0 = tlDly; g1 = iDATA;  b = rdData; end
      BGGR:    begin r = iDATA;  g0 = rdData; g1 = blDly; b = tlDly;  end
      default: ;
    endcase
  end

  assign greenSum = {1'b0, g0} + {1'b0, g1};

`ifdef DEMOSAIC_GRAY_EN
  logic              grayLat;
  logic [DATA_W+1:0] graySum;

  assign graySum = (DATA_W+2)'(r) + (DATA_W+2)'(g0) + (DATA_W+2)'(g1) + (DATA_W+2)'(b);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)            grayLat <= 1'b0;
    else if (frameStart) grayLat <= iGray;
  end

  always_comb begin
    nextRed   = r;
    nextGreen = greenSum[DATA_W:1];
    nextBlue  = b;
    if (grayLat) begin
      nextRed   = graySum[DATA_W+1:2];
      nextGreen = graySum[DATA_W+1:2];
      nextBlue  = graySum[DATA_W+1:2];
    end
  end
`else
  logic unusedGray;
  assign unusedGray = iGray;

  always_comb begin
    nextRed   = r;
    nextGreen = greenSum[DATA_W:1];
    nextBlue  = b;
  end
`endif

  // Delay taps, frame-level latches and the registered pixel output.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      blDly   <= '0;
      tlDly   <= '0;
      patLat  <= RGGB;
      primed  <= 1'b0;
      sofPend <= 1'b0;
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oDVAL   <= 1'b0;
      oSOF    <= 1'b0;
    end else begin
      oDVAL <= quadEvt;
      oSOF  <= 1'b0;
      if (accept) begin
        blDly <= iDATA;
        tlDly <= rdData;
      end
      if (primeEvt) primed <= 1'b1;
      if (quadEvt) begin
        oRed    <= nextRed;
        oGreen  <= nextGreen;
        oBlue   <= nextBlue;
        oSOF    <= sofPend;
        sofPend <= 1'b0;
      end
      if (frameStart) begin
        patLat  <= bayer_pat_e'(iPattern);
        sofPend <= 1'b1;
      end
    end
  end

endmodule
